apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

APB requester that turns a simple valid/ready command stream into APB setup/access transfers toward the APB memory slave, and returns one response per command. It sits directly upstream of the APB memory slave on the same `pclk` domain. It issues one transfer at a time and bounds slave wait states with a timeout that converts a hung slave into an error response.

## Interface
- `ADDR_W`, 32, width of `cmd_addr` and `paddr`
- `DATA_W`, 32, width of the write and read data paths
- `TIMEOUT`, 16, maximum ACCESS cycles with `pready` low before abort; legal range 1..65535
- `pclk`  in  1  the single clock; all logic is on its rising edge
- `prst`  in  1  reset, synchronous and active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when `cmd_valid` is also high
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  transfer address
- `cmd_wdata`  in  DATA_W  write data; ignored for reads
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when `rsp_valid` is also high
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and for aborted transfers
- `rsp_err`  out  1  `pslverr` was sampled high, or the transfer timed out
- `paddr`, `pwrite`, `pwdata`  out  ADDR_W/1/DATA_W  APB address, direction and write data
- `pselx`, `penable`  out  1  APB select and enable
- `pready`, `pslverr`  in  1  APB slave ready and error
- `prdata`  in  DATA_W  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB and rsp outputs are registered. `cmd_ready` = (state == IDLE) and is combinational from state only.
- **IDLE:** on `cmd_valid`:
  - capture `cmd_*` into `paddr`/`pwrite`/`pwdata`;
  - set `pselx`=1, `penable`=0;
  - go to SETUP.
- **SETUP:** lasts exactly one cycle. Set `penable`=1, clear the wait counter, go to ACCESS.
- **ACCESS, `pready` sampled 1:**
  - set `pselx`=`penable`=0;
  - set `rsp_err`=`pslverr`;
  - set `rsp_rdata`=`prdata` for a read, 0 for a write;
  - set `rsp_valid`=1 and go to RESP.
- **ACCESS, `pready` sampled 0:** increment the wait counter.
  - When this is the TIMEOUT-th consecutive low cycle, abort: `pselx`=`penable`=0, `rsp_err`=1, `rsp_rdata`=0, `rsp_valid`=1, go to RESP.
  - `pready`=1 in the TIMEOUT-th cycle completes normally; pready has priority over timeout.
- **RESP:** hold `rsp_*` stable until `rsp_valid && rsp_ready`. Then clear `rsp_valid` and go to IDLE. No new command is accepted while in RESP.
- `paddr`, `pwrite` and `pwdata` are stable from SETUP through the end of ACCESS and hold their last value afterwards.
- Wait counter width is clog2(TIMEOUT+1) and it saturates; it never wraps.
- **Reset:** state IDLE and every output 0 (`paddr`, `pwdata`, `pwrite`, `pselx`, `penable`, `rsp_valid`, `rsp_rdata`, `rsp_err`). `cmd_ready`=1 in the first cycle after reset deasserts.
- **Reset mid-transfer:** `pselx`/`penable` drop at that edge, the in-flight command is discarded, and no response is produced.

## Timing
- Command accepted at edge N → `pselx`=1 from N.
- `penable`=1 from N+1.
- Zero-wait slave (`pready`=1 in the first ACCESS cycle): `pselx`/`penable` drop and `rsp_valid`=1 from N+2.
- Each slave wait state adds one cycle.
- Timeout abort: `rsp_valid` rises TIMEOUT cycles after `penable` rose.
- Minimum command-to-command spacing is 4 cycles with `rsp_ready` held high: IDLE, SETUP, ACCESS, RESP.
- `rsp_rdata` and `rsp_err` change only on the edge that sets `rsp_valid`.

## Structure
- Package `apb_pkg` holds:
  - the FSM state enum (`APB_IDLE`, `APB_SETUP`, `APB_ACCESS`, `APB_RESP`), 2 bits, encoded to match the slave's state encoding;
  - default `ADDR_W` and `DATA_W` constants.
- One sub-module, `apb_wait_timer`:
  - inputs: clear, enable (ACCESS && !`pready`), `TIMEOUT` parameter;
  - output: expired pulse.
- Everything else is flat in `apb_master_bridge`.

## Test plan
- Zero-wait write then read:
  - write addr 5 data 0xDEADBEEF, then read addr 5 with the APB memory slave attached;
  - expect `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, and `rsp_valid` 2 cycles after each accept.
- Wait states: slave holds `pready` low 3 cycles on a read of addr 7 → `penable` high 4 cycles, `paddr` stable at 7 throughout, `rsp_valid` 5 cycles after accept.
- Timeout, with TIMEOUT=4:
  - `pready` tied 0 → abort after 4 ACCESS cycles with `rsp_err`=1 and `rsp_rdata`=0;
  - repeat with `pready`=1 in the 4th cycle → normal completion with `rsp_err`=0.
- Slave error: `pslverr`=1 with `pready` on a write → `rsp_err`=1, `rsp_rdata`=0.
- Backpressure: hold `rsp_ready`=0 for 6 cycles with `cmd_valid` high → `cmd_ready`=0, `rsp_*` stable, no new `pselx` until the cycle after the handshake.
- Reset mid-ACCESS: assert `prst` for 1 cycle during wait states → `pselx`/`penable`/`rsp_valid` are 0 the next cycle, no response emitted, and the next command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB requester.
// Holds the FSM state encoding (same encoding as the APB memory slave)
// and the default address/data widths.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2,
        APB_RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Bundles the command stream, response stream and APB pins of the requester.
// master: the bridge's view (drives APB and rsp, receives cmd and slave pins).
// slave: the surrounding view (drives cmd, rsp_ready and slave pins).
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    // command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // response stream
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // APB requester pins
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              pselx;
    logic              penable;
    logic              pready;
    logic              pslverr;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  pready, pslverr, prdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwrite, pwdata, pselx, penable
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output pready, pslverr, prdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwrite, pwdata, pselx, penable
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts consecutive ACCESS cycles with pready low and flags the TIMEOUT-th one.
// Latency: o_expired is combinational in the cycle that is the TIMEOUT-th low cycle.
// Backpressure: none; the counter saturates instead of wrapping.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST_LOW = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   SAT      = CW'(TIMEOUT);

    logic [CW-1:0] r_count;

    // count low-pready cycles, cleared at the start of every transfer, saturating
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != SAT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // r_count holds the number of earlier low cycles, so this is the TIMEOUT-th one
    assign o_expired = i_enable && (r_count == LAST_LOW);

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: one valid/ready command becomes one APB setup/access transfer and one response.
// Latency: pselx with the accept edge, penable one edge later, rsp_valid 2 edges after accept plus slave waits.
// Backpressure: cmd_ready only in IDLE; rsp held until rsp_ready; hung slave aborted after TIMEOUT wait cycles.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                prst,
    apb_master_bridge_if.master bus
);

    apb_state_t        r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_paddr,     w_paddr_nxt;
    logic              r_pwrite,    w_pwrite_nxt;
    logic [DATA_W-1:0] r_pwdata,    w_pwdata_nxt;
    logic              r_pselx,     w_pselx_nxt;
    logic              r_penable,   w_penable_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err,   w_rsp_err_nxt;

    logic w_timer_clr;
    logic w_timer_en;
    logic w_expired;

    assign w_timer_clr = (r_state == APB_SETUP);
    assign w_timer_en  = (r_state == APB_ACCESS) && !bus.pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk     (pclk),
        .i_rst     (prst),
        .i_clear   (w_timer_clr),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    // next state and next values of every registered output
    always_comb begin
        w_state_nxt     = r_state;
        w_paddr_nxt     = r_paddr;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_pselx_nxt     = r_pselx;
        w_penable_nxt   = r_penable;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            APB_IDLE: begin
                if (bus.cmd_valid) begin
                    w_paddr_nxt   = bus.cmd_addr;
                    w_pwrite_nxt  = bus.cmd_write;
                    w_pwdata_nxt  = bus.cmd_wdata;
                    w_pselx_nxt   = 1'b1;
                    w_penable_nxt = 1'b0;
                    w_state_nxt   = APB_SETUP;
                end
            end
            APB_SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = APB_ACCESS;
            end
            APB_ACCESS: begin
                // pready wins over an expiry landing in the same cycle
                if (bus.pready) begin
                    w_pselx_nxt     = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_err_nxt   = bus.pslverr;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : bus.prdata;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = APB_RESP;
                end else if (w_expired) begin
                    w_pselx_nxt     = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = APB_RESP;
                end
            end
            APB_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = APB_IDLE;
                end
            end
            default: begin
                w_state_nxt = APB_IDLE;
            end
        endcase
    end

    // state and output registers; reset drops any in-flight transfer without a response
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state     <= APB_IDLE;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pselx     <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pselx     <= w_pselx_nxt;
            r_penable   <= w_penable_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign bus.cmd_ready = (r_state == APB_IDLE);
    assign bus.paddr     = r_paddr;
    assign bus.pwrite    = r_pwrite;
    assign bus.pwdata    = r_pwdata;
    assign bus.pselx     = r_pselx;
    assign bus.penable   = r_penable;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios plus random traffic, all checked
// every cycle against a transaction-schedule model (accept edge, completion edge,
// handshake edge) and a bench-side APB memory slave.
module tb_apb_master_bridge;

    localparam int T = 4;

    logic pclk = 1'b0;
    logic prst;
    always #5 pclk = ~pclk;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (T)
    ) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int e     = 0;      // number of rising edges so far

    // slave behaviour attached to the command currently presented
    int   nxt_w;        // pready-low cycles before pready rises (>= T means never)
    logic nxt_err;

    // bench-side slave memory
    logic [31:0] mem [16];

    // model of the transaction in flight
    bit          busy;
    int          acc, done, t_w;
    logic        t_err;
    logic        m_rv, m_re, m_pwrite;
    logic [31:0] m_rd, m_paddr, m_pwdata;

    // observations used by directed literal checks
    bit          acc_seen;
    int          dut_acc, dut_rise, pen_cnt;
    logic        prev_rv;
    logic [31:0] cap_rd;
    logic        cap_re;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s edge %0d got %h expected %h", nm, e, act, exp);
        end
    endtask

    // slave pins for the coming edge, driven from the model's schedule
    task automatic drive_slave();
        bit in_access, rdy;
        in_access = busy && !m_rv && (e + 1 >= acc + 2);
        rdy       = in_access && (t_w < T) && (e + 1 == acc + 2 + t_w);
        bus.pready  = in_access ? rdy : 1'($urandom_range(0, 1));
        bus.pslverr = rdy ? t_err : 1'($urandom_range(0, 1));
        bus.prdata  = (rdy && !m_pwrite) ? mem[m_paddr[3:0]] : $urandom;
    endtask

    task automatic model_edge();
        e++;
        if (prst) begin
            busy = 0; m_rv = 0; m_re = 0; m_rd = 0;
            m_paddr = 0; m_pwrite = 0; m_pwdata = 0;
        end else if (!busy) begin
            if (bus.cmd_valid) begin
                busy     = 1;
                acc      = e;
                m_paddr  = bus.cmd_addr;
                m_pwrite = bus.cmd_write;
                m_pwdata = bus.cmd_wdata;
                t_w      = nxt_w;
                t_err    = nxt_err;
                done     = (t_w < T) ? acc + 2 + t_w : acc + 1 + T;
            end
        end else if (e == done) begin
            m_rv = 1;
            if (t_w < T) begin
                m_re = t_err;
                m_rd = m_pwrite ? 32'h0 : mem[m_paddr[3:0]];
                if (m_pwrite && !t_err) mem[m_paddr[3:0]] = m_pwdata;
            end else begin
                m_re = 1;
                m_rd = 0;
            end
        end else if (m_rv && bus.rsp_ready) begin
            m_rv = 0;
            busy = 0;
        end
    endtask

    task automatic compare();
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(!busy));
        chk("pselx",     32'(bus.pselx),     32'(busy && e < done));
        chk("penable",   32'(bus.penable),   32'(busy && e > acc && e < done));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
        chk("rsp_rdata", bus.rsp_rdata,      m_rd);
        chk("rsp_err",   32'(bus.rsp_err),   32'(m_re));
        chk("paddr",     bus.paddr,          m_paddr);
        chk("pwrite",    32'(bus.pwrite),    32'(m_pwrite));
        chk("pwdata",    bus.pwdata,         m_pwdata);
        if (bus.penable === 1'b1) pen_cnt++;
        if (bus.rsp_valid === 1'b1 && prev_rv !== 1'b1) begin
            dut_rise = e;
            cap_rd   = bus.rsp_rdata;
            cap_re   = bus.rsp_err;
        end
        prev_rv = bus.rsp_valid;
    endtask

    task automatic step();
        drive_slave();
        acc_seen = (bus.cmd_valid === 1'b1) && (bus.cmd_ready === 1'b1) && !prst;
        @(posedge pclk);
        model_edge();
        #1;
        if (acc_seen) begin
            dut_acc = e;
            pen_cnt = 0;
        end
        compare();
    endtask

    // present one command, wait for its response, stall rsp_ready for 'hold' cycles
    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input int w, input logic er, input int hold, input bit keep);
        int g;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        nxt_w         = w;
        nxt_err       = er;
        bus.rsp_ready = 1'b0;
        g = 0;
        do begin
            step();
            g++;
        end while (!acc_seen && g < 20);
        chk("accept_seen", 32'(acc_seen), 32'd1);
        if (!keep) bus.cmd_valid = 1'b0;
        g = 0;
        while (bus.rsp_valid !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
        for (int i = 0; i < hold; i++) step();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        prst = 1'b1;
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
        bus.rsp_ready = 0; bus.pready = 0; bus.pslverr = 0; bus.prdata = 0;
        nxt_w = 0; nxt_err = 0;
        busy = 0; acc = 0; done = 0; t_w = 0; t_err = 0;
        m_rv = 0; m_re = 0; m_rd = 0; m_paddr = 0; m_pwrite = 0; m_pwdata = 0;
        acc_seen = 0; dut_acc = 0; dut_rise = 0; pen_cnt = 0; prev_rv = 0;
        cap_rd = 0; cap_re = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[7] = 32'h0BAD_F00D;
        mem[9] = 32'h1234_5678;

        // reset state
        step();
        step();
        prst = 1'b0;
        chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("reset_paddr", bus.paddr, 32'd0);

        // zero-wait write then read of the same address
        do_cmd(1'b1, 32'd5, 32'hDEAD_BEEF, 0, 1'b0, 0, 1'b0);
        chk("wr_latency", 32'(dut_rise - dut_acc), 32'd2);
        chk("wr_err", 32'(cap_re), 32'd0);
        chk("wr_rdata_zero", cap_rd, 32'd0);
        do_cmd(1'b0, 32'd5, 32'h0, 0, 1'b0, 0, 1'b0);
        chk("rd_latency", 32'(dut_rise - dut_acc), 32'd2);
        chk("rd_data", cap_rd, 32'hDEAD_BEEF);
        chk("rd_err", 32'(cap_re), 32'd0);

        // three wait states on a read of addr 7
        do_cmd(1'b0, 32'd7, 32'h0, 3, 1'b0, 0, 1'b0);
        chk("wait_latency", 32'(dut_rise - dut_acc), 32'd5);
        chk("wait_penable_cycles", 32'(pen_cnt), 32'd4);
        chk("wait_data", cap_rd, 32'h0BAD_F00D);
        chk("wait_paddr", bus.paddr, 32'd7);

        // hung slave: abort after T low cycles
        do_cmd(1'b0, 32'd9, 32'h0, 100, 1'b0, 0, 1'b0);
        chk("timeout_latency", 32'(dut_rise - dut_acc), 32'd5);
        chk("timeout_err", 32'(cap_re), 32'd1);
        chk("timeout_rdata", cap_rd, 32'd0);

        // pready in the T-th cycle completes normally
        do_cmd(1'b0, 32'd9, 32'h0, 3, 1'b0, 0, 1'b0);
        chk("edge_latency", 32'(dut_rise - dut_acc), 32'd5);
        chk("edge_err", 32'(cap_re), 32'd0);
        chk("edge_data", cap_rd, 32'h1234_5678);

        // slave error on a write
        do_cmd(1'b1, 32'd3, 32'hCAFE_F00D, 1, 1'b1, 0, 1'b0);
        chk("slverr_err", 32'(cap_re), 32'd1);
        chk("slverr_rdata", cap_rd, 32'd0);

        // response backpressure with the next command already waiting
        do_cmd(1'b1, 32'd2, 32'hA5A5_A5A5, 0, 1'b0, 6, 1'b1);
        chk("bp_pselx_after_hs", 32'(bus.pselx), 32'd0);
        chk("bp_cmd_ready_after_hs", 32'(bus.cmd_ready), 32'd1);
        do_cmd(1'b0, 32'd2, 32'h0, 2, 1'b0, 0, 1'b0);
        chk("bp_read_data", cap_rd, 32'hA5A5_A5A5);

        // reset during ACCESS wait states
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'd7;
        nxt_w = 3; nxt_err = 1'b0;
        for (int g = 0; g < 20 && !acc_seen; g++) step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        prst = 1'b1;
        step();
        prst = 1'b0;
        chk("rst_pselx", 32'(bus.pselx), 32'd0);
        chk("rst_penable", 32'(bus.penable), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        for (int i = 0; i < 8; i++) step();
        do_cmd(1'b0, 32'd7, 32'h0, 0, 1'b0, 0, 1'b0);
        chk("post_rst_latency", 32'(dut_rise - dut_acc), 32'd2);
        chk("post_rst_data", cap_rd, 32'h0BAD_F00D);

        // random traffic
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (bus.cmd_valid !== 1'b1 || acc_seen) begin
                bus.cmd_valid = ($urandom_range(0, 9) < 7);
                bus.cmd_write = 1'($urandom_range(0, 1));
                bus.cmd_addr  = 32'($urandom_range(0, 15));
                bus.cmd_wdata = $urandom;
                nxt_w         = int'($urandom_range(0, 6));
                nxt_err       = ($urandom_range(0, 3) == 0);
            end
            bus.rsp_ready = ($urandom_range(0, 9) < 6);
            prst          = ($urandom_range(0, 99) == 0);
            step();
        end
        prst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
